// File: rtl/gray_counter_n.sv
// Parametrised Gray-code counter: up/down, wrap or saturate, sticky over/underflow
// flags and a one-cycle terminal pulse. Define GRAY_LOAD_EN to add the Ld/LdVal load port.
module gray_counter_n #(
  parameter int WIDTH = 3,
  parameter bit WRAP  = 1'b1
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             En,
  input  logic             Dir,
  input  logic             Clr,
`ifdef GRAY_LOAD_EN
  input  logic             Ld,
  input  logic [WIDTH-1:0] LdVal,
`endif
  output logic [WIDTH-1:0] Output,
  output logic [WIDTH-1:0] Bin,
  output logic             Overflow,
  output logic             Underflow,
  output logic             Term
);

  localparam logic [WIDTH-1:0] MAX = '1;

  logic [WIDTH-1:0] r_bin;
  logic [WIDTH-1:0] r_gray;
  logic             r_ovf;
  logic             r_unf;
  logic             r_term;

  logic [WIDTH-1:0] w_bin_nxt;
  logic [WIDTH-1:0] w_gray_nxt;
  logic             w_ovf_nxt;
  logic             w_unf_nxt;
  logic             w_term_nxt;
  logic             w_ld;
  logic [WIDTH-1:0] w_ld_bin;

`ifdef GRAY_LOAD_EN
  // Gray-to-binary: bit i is the XOR of all Gray bits from the MSB down to i.
  always_comb begin
    w_ld_bin = '0;
    for (int i = 0; i < WIDTH; i++) begin
      w_ld_bin[i] = ^(LdVal >> i);
    end
  end
  assign w_ld = Ld;
`else
  assign w_ld_bin = '0;
  assign w_ld     = 1'b0;
`endif

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    w_bin_nxt  = r_bin;
    w_ovf_nxt  = r_ovf;
    w_unf_nxt  = r_unf;
    w_term_nxt = 1'b0;
    if (Clr) begin
      w_bin_nxt = '0;
      w_ovf_nxt = 1'b0;
      w_unf_nxt = 1'b0;
    end else if (w_ld) begin
      w_bin_nxt = w_ld_bin;
    end else if (En) begin
      if (Dir) begin
        if (r_bin == MAX) begin
          w_bin_nxt  = WRAP ? '0 : MAX;
          w_ovf_nxt  = 1'b1;
          w_term_nxt = 1'b1;
        end else begin
          w_bin_nxt = r_bin + 1'b1;
        end
      end else begin
        if (r_bin == '0) begin
          w_bin_nxt  = WRAP ? MAX : '0;
          w_unf_nxt  = 1'b1;
          w_term_nxt = 1'b1;
        end else begin
          w_bin_nxt = r_bin - 1'b1;
        end
      end
    end
  end

  // Gray is encoded from the next count so Output is registered alongside Bin.
  assign w_gray_nxt = w_bin_nxt ^ (w_bin_nxt >> 1);

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      r_bin  <= '0;
      r_gray <= '0;
      r_ovf  <= 1'b0;
      r_unf  <= 1'b0;
      r_term <= 1'b0;
    end else begin
      r_bin  <= w_bin_nxt;
      r_gray <= w_gray_nxt;
      r_ovf  <= w_ovf_nxt;
      r_unf  <= w_unf_nxt;
      r_term <= w_term_nxt;
    end
  end

  assign Output    = r_gray;
  assign Bin       = r_bin;
  assign Overflow  = r_ovf;
  assign Underflow = r_unf;
  assign Term      = r_term;

endmodule

// File: tb/tb_gray_counter_n.sv
// Scoreboard bench for gray_counter_n: a wrapping and a saturating WIDTH=3 instance
// share stimulus; expected values are hand-computed and checked by a separate monitor.
module tb_gray_counter_n;

  logic       Clk   = 1'b0;
  logic       Reset = 1'b1;
  logic       Clr   = 1'b0;
  logic       Dir   = 1'b0;
  logic       en_w  = 1'b0;
  logic       en_s  = 1'b0;
`ifdef GRAY_LOAD_EN
  logic       ld    = 1'b0;
  logic [2:0] ldval = 3'b000;
`endif

  logic [2:0] gray_w, bin_w, gray_s, bin_s;
  logic       ovf_w, unf_w, term_w, ovf_s, unf_s, term_s;

  always #5 Clk = ~Clk;

  gray_counter_n #(.WIDTH(3), .WRAP(1'b1)) u_wrap (
    .Clk(Clk), .Reset(Reset), .En(en_w), .Dir(Dir), .Clr(Clr),
`ifdef GRAY_LOAD_EN
    .Ld(ld), .LdVal(ldval),
`endif
    .Output(gray_w), .Bin(bin_w), .Overflow(ovf_w), .Underflow(unf_w), .Term(term_w)
  );

  gray_counter_n #(.WIDTH(3), .WRAP(1'b0)) u_sat (
    .Clk(Clk), .Reset(Reset), .En(en_s), .Dir(Dir), .Clr(Clr),
`ifdef GRAY_LOAD_EN
    .Ld(ld), .LdVal(ldval),
`endif
    .Output(gray_s), .Bin(bin_s), .Overflow(ovf_s), .Underflow(unf_s), .Term(term_s)
  );

  typedef struct {
    string      name;
    bit         sat;
    logic [2:0] bin;
    logic [2:0] gray;
    logic       ovf;
    logic       unf;
    logic       term;
  } exp_t;

  exp_t q[$];
  int   n_total  = 0;
  int   n_passed = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_total++;
    if (act !== req) $display("FAIL %s: got %0h, expected %0h", name, act, req);
    else n_passed++;
  endtask

  task automatic push(input string name, input bit sat, input logic [2:0] bin,
                      input logic [2:0] gray, input logic ovf, input logic unf,
                      input logic term);
    exp_t e;
    e.name = name; e.sat = sat; e.bin = bin; e.gray = gray;
    e.ovf = ovf; e.unf = unf; e.term = term;
    q.push_back(e);
  endtask

  task automatic drive(input logic clr, input logic ew, input logic es, input logic dir);
    @(negedge Clk);
    Clr = clr; en_w = ew; en_s = es; Dir = dir;
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_w_bin"},  {29'd0, bin_w},  32'd0);
    check({tag, "_w_gray"}, {29'd0, gray_w}, 32'd0);
    check({tag, "_w_flags"}, {29'd0, ovf_w, unf_w, term_w}, 32'd0);
    check({tag, "_s_bin"},  {29'd0, bin_s},  32'd0);
    check({tag, "_s_flags"}, {29'd0, ovf_s, unf_s, term_s}, 32'd0);
  endtask

  // Monitor: outputs update on every edge, so every queued expectation is due by posedge+2.
  initial begin
    exp_t e;
    forever begin
      @(posedge Clk);
      #2;
      while (q.size() > 0) begin
        e = q.pop_front();
        if (e.sat) begin
          check({e.name, "_s_bin"},  {29'd0, bin_s},  {29'd0, e.bin});
          check({e.name, "_s_gray"}, {29'd0, gray_s}, {29'd0, e.gray});
          check({e.name, "_s_ovf"},  {31'd0, ovf_s},  {31'd0, e.ovf});
          check({e.name, "_s_unf"},  {31'd0, unf_s},  {31'd0, e.unf});
          check({e.name, "_s_term"}, {31'd0, term_s}, {31'd0, e.term});
        end else begin
          check({e.name, "_w_bin"},  {29'd0, bin_w},  {29'd0, e.bin});
          check({e.name, "_w_gray"}, {29'd0, gray_w}, {29'd0, e.gray});
          check({e.name, "_w_ovf"},  {31'd0, ovf_w},  {31'd0, e.ovf});
          check({e.name, "_w_unf"},  {31'd0, unf_w},  {31'd0, e.unf});
          check({e.name, "_w_term"}, {31'd0, term_w}, {31'd0, e.term});
        end
      end
    end
  end

  logic [2:0] up_g [8];
  logic [2:0] w_seq [6];
  logic [2:0] s_seq [6];

  initial begin
    up_g  = '{3'b000, 3'b001, 3'b011, 3'b010, 3'b110, 3'b111, 3'b101, 3'b100};
    w_seq = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5};
    s_seq = '{3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7};

    #1 Reset = 1'b0;
    #1 check_zero("reset");
    @(negedge Clk) Reset = 1'b1;

    // Up count, edges 1..7
    for (int k = 1; k < 8; k++) begin
      drive(1'b0, 1'b1, 1'b1, 1'b1);
      push("up", 1'b0, 3'(k), up_g[k], 1'b0, 1'b0, 1'b0);
      push("up", 1'b1, 3'(k), up_g[k], 1'b0, 1'b0, 1'b0);
    end
    drive(1'b0, 1'b1, 1'b1, 1'b1);
    push("edge8", 1'b0, 3'd0, 3'b000, 1'b1, 1'b0, 1'b1);
    push("edge8", 1'b1, 3'd7, 3'b100, 1'b1, 1'b0, 1'b1);
    drive(1'b0, 1'b1, 1'b1, 1'b1);
    push("edge9", 1'b0, 3'd1, 3'b001, 1'b1, 1'b0, 1'b0);
    push("edge9", 1'b1, 3'd7, 3'b100, 1'b1, 1'b0, 1'b1);
    drive(1'b0, 1'b1, 1'b1, 1'b1);
    push("edge10", 1'b0, 3'd2, 3'b011, 1'b1, 1'b0, 1'b0);
    push("edge10", 1'b1, 3'd7, 3'b100, 1'b1, 1'b0, 1'b1);

    // Clr beats En and clears the sticky flag
    drive(1'b1, 1'b1, 1'b1, 1'b1);
    push("clr", 1'b0, 3'd0, 3'b000, 1'b0, 1'b0, 1'b0);
    push("clr", 1'b1, 3'd0, 3'b000, 1'b0, 1'b0, 1'b0);

    // Down from zero
    drive(1'b0, 1'b1, 1'b1, 1'b0);
    push("dn0", 1'b0, 3'd7, 3'b100, 1'b0, 1'b1, 1'b1);
    push("dn0", 1'b1, 3'd0, 3'b000, 1'b0, 1'b1, 1'b1);
    drive(1'b0, 1'b1, 1'b1, 1'b0);
    push("dn1", 1'b0, 3'd6, 3'b101, 1'b0, 1'b1, 1'b0);
    push("dn1", 1'b1, 3'd0, 3'b000, 1'b0, 1'b1, 1'b1);

    drive(1'b0, 1'b0, 1'b0, 1'b0);
    push("hold", 1'b0, 3'd6, 3'b101, 1'b0, 1'b1, 1'b0);
    push("hold", 1'b1, 3'd0, 3'b000, 1'b0, 1'b1, 1'b0);

    drive(1'b0, 1'b1, 1'b1, 1'b1);
    push("dirchg", 1'b0, 3'd7, 3'b100, 1'b0, 1'b1, 1'b0);
    push("dirchg", 1'b1, 3'd1, 3'b001, 1'b0, 1'b1, 1'b0);

    // Wrapping instance passes through MAX again and reaches 5
    for (int k = 0; k < 6; k++) begin
      drive(1'b0, 1'b1, 1'b1, 1'b1);
      push("run", 1'b0, w_seq[k], up_g[w_seq[k]], 1'b1, 1'b1, (k == 0) ? 1'b1 : 1'b0);
      push("run", 1'b1, s_seq[k], up_g[s_seq[k]], 1'b0, 1'b1, 1'b0);
    end

    // Asynchronous reset between edges, held across an enabled edge
    @(posedge Clk);
    #2 Reset = 1'b0;
    #1 check_zero("async_rst");
    @(posedge Clk);
    #2 check_zero("rst_held");
    drive(1'b0, 1'b1, 1'b1, 1'b1);
    Reset = 1'b1;
    push("resume", 1'b0, 3'd1, 3'b001, 1'b0, 1'b0, 1'b0);
    push("resume", 1'b1, 3'd1, 3'b001, 1'b0, 1'b0, 1'b0);

`ifdef GRAY_LOAD_EN
    drive(1'b0, 1'b1, 1'b1, 1'b1);
    ld = 1'b1; ldval = 3'b110;
    push("load", 1'b0, 3'd4, 3'b110, 1'b0, 1'b0, 1'b0);
    push("load", 1'b1, 3'd4, 3'b110, 1'b0, 1'b0, 1'b0);
    drive(1'b0, 1'b1, 1'b1, 1'b1);
    ld = 1'b0;
    push("postload", 1'b0, 3'd5, 3'b111, 1'b0, 1'b0, 1'b0);
    push("postload", 1'b1, 3'd5, 3'b111, 1'b0, 1'b0, 1'b0);
`endif

    drive(1'b0, 1'b0, 1'b0, 1'b0);
    @(posedge Clk);
    #3 check("sb_drain", q.size(), 32'd0);
    $display("%0d/%0d checks passed", n_passed, n_total);
    $finish;
  end

endmodule

// File: doc/gray_counter_n.md
# gray_counter_n

Parametrised Gray-code counter that generalises the fixed 3-bit up-counter in the P1 exercise set. It supports configurable width, up/down counting, wrap or saturate at the terminal count, sticky overflow and underflow flags, and a one-cycle terminal pulse. The block is fully synchronous to `Clk` apart from its asynchronous reset. It is intended as the shared counter primitive for later P-series sequencers and for clock-domain pointer encoding.

## Interface
Parameters:
- `WIDTH`, default 3: counter width in bits; legal range 2..16.
- `WRAP`, default 1: 1 wraps at the terminal count, 0 saturates at the terminal count.

Ports:
- `Clk`: input, 1 bit, rising-edge clock.
- `Reset`: input, 1 bit, asynchronous, active-low reset.
- `En`: input, 1 bit, count enable.
- `Dir`: input, 1 bit, direction; 1 counts up, 0 counts down.
- `Clr`: input, 1 bit, synchronous clear of the count and both flags.
- `Ld`: input, 1 bit, synchronous load strobe (present only with `GRAY_LOAD_EN`).
- `LdVal`: input, `WIDTH` bits, Gray-coded load value (present only with `GRAY_LOAD_EN`).
- `Output`: output, `WIDTH` bits, registered Gray code of the count.
- `Bin`: output, `WIDTH` bits, registered binary count.
- `Overflow`: output, 1 bit, sticky; set on an up-step attempted from MAX.
- `Underflow`: output, 1 bit, sticky; set on a down-step attempted from 0.
- `Term`: output, 1 bit, one-cycle pulse on any terminal event.

## Operation
- Internal state is a `WIDTH`-bit binary count `B`.
  - `Bin` = `B`.
  - `Output` = `B ^ (B >> 1)`.
  - Both outputs are registered; there is no combinational path from inputs to outputs.
- MAX = 2^WIDTH − 1. All arithmetic is modulo 2^WIDTH; no wider counter exists internally.
- Priority at each rising edge of `Clk`: `Reset` (async) > `Clr` > `Ld` > `En` > hold.
- `Reset` low, asynchronously:
  - `B`=0, `Output`=0, `Bin`=0.
  - `Overflow`=0, `Underflow`=0, `Term`=0.
  - This holds while `Reset` is low, including mid-count.
- `Clr`=1:
  - `B`=0; `Overflow`=0; `Underflow`=0; `Term`=0.
  - `En`, `Dir` and `Ld` are ignored that cycle.
- `Ld`=1:
  - `B` = Gray-to-binary of `LdVal` (prefix XOR from the MSB down).
  - Flags are unchanged; `Term`=0.
- `En`=1, `Dir`=1:
  - `B` < MAX: `B`+1.
  - `B` = MAX, `WRAP`=1: `B`=0; `Overflow`←1; `Term` pulses.
  - `B` = MAX, `WRAP`=0: `B` holds at MAX; `Overflow`←1; `Term` pulses.
- `En`=1, `Dir`=0:
  - `B` > 0: `B`−1.
  - `B` = 0, `WRAP`=1: `B`=MAX; `Underflow`←1; `Term` pulses.
  - `B` = 0, `WRAP`=0: `B` holds at 0; `Underflow`←1; `Term` pulses.
- In saturate mode, `Term` pulses on every enabled cycle that attempts to step past the terminal count.
- `En`=0: everything holds and `Term`=0.
- The flags stay set until `Clr` or `Reset`; further counting does not clear them.
- `Dir` may change on any cycle; the new direction takes effect on the same edge.

## Timing
- Latency is one cycle: an input sampled at edge k is visible on `Output`, `Bin` and the flags after edge k.
- `Term` is high for exactly the one cycle following the terminal edge.
- Between any two consecutive enabled steps, `Output` changes in exactly one bit, including across the wrap.
  - `Ld` and `Clr` are exempt from this rule.
- Reset assertion takes effect asynchronously. Release is synchronous in effect: the first count happens at the first rising edge with `Reset` high and `En`=1.

## Configuration
- `GRAY_LOAD_EN` defined:
  - The `Ld` and `LdVal` ports exist.
  - The load behaviour above is active.
- `GRAY_LOAD_EN` undefined:
  - The `Ld` and `LdVal` ports are removed.
  - The priority chain becomes `Reset` > `Clr` > `En`.
  - All other behaviour is identical.

## Test plan
All scenarios use WIDTH=3 unless stated.
- Reset low, then `En`=1, `Dir`=1 for 9 cycles -> `Output` follows 000,001,011,010,110,111,101,100,000; `Overflow`=1 after the 8th edge; `Term` is high for exactly one cycle.
- `WRAP`=0, `Dir`=1, 10 enabled cycles -> `Bin` holds at 7 and `Output` at 100; `Overflow`=1; `Term` pulses on edges 8, 9 and 10.
- `Dir`=0 from 0 with `WRAP`=1 -> `Bin`=7, `Output`=100, `Underflow`=1, `Overflow` stays 0; the next step gives `Bin`=6, `Output`=101.
- `Reset` pulled low mid-count at `Bin`=5, asynchronously between edges -> all outputs go to 0 immediately, without waiting for an edge; counting resumes from 0 after release.
- `Clr` and `En` both asserted with `Overflow`=1 -> `Bin`=0 and `Overflow`=0; `Clr` wins.
- With `GRAY_LOAD_EN`, `Ld`=1 and `LdVal`=110 -> `Bin`=4; the next up-step gives `Output`=111; a simultaneous `En` is ignored on the load cycle.
